// File: rtl/bitmanip_rot_pipe_if.sv
// Request/response bundle for the rotate pipe: operand request in, rotated result out,
// each side with its own valid/ready pair.
interface bitmanip_rot_pipe_if #(
    parameter int SIZE  = 16,
    parameter int TAG_W = 4
);
    localparam int SHAMT_SIZE = $clog2(SIZE);

    logic                  valid_i;
    logic                  ready_o;
    logic [SIZE-1:0]       data_i;
    logic [SHAMT_SIZE-1:0] shamt_i;
    logic                  dir_i;
    logic [TAG_W-1:0]      tag_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [SIZE-1:0]       result_o;
    logic [TAG_W-1:0]      tag_o;

    modport master (
        output valid_i, data_i, shamt_i, dir_i, tag_i, ready_i,
        input  ready_o, valid_o, result_o, tag_o
    );

    modport slave (
        input  valid_i, data_i, shamt_i, dir_i, tag_i, ready_i,
        output ready_o, valid_o, result_o, tag_o
    );
endinterface

// File: rtl/bitmanip_rot_pipe.sv
// Two-stage rotate unit: S1 normalizes ROR to ROL, S2 rotates; valid_o two edges after accept.
// Full backpressure: holds up to two results, ready_o is combinational from ready_i.
module bitmanip_rot_pipe #(
    parameter int SIZE       = 16,
    parameter int SHAMT_SIZE = $clog2(SIZE),
    parameter int TAG_W      = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    bitmanip_rot_pipe_if.slave   bus,
    output logic [CNT_W-1:0]     ops_cnt_o
);
    logic                  s1_valid;
    logic [SIZE-1:0]       s1_data;
    logic [SHAMT_SIZE-1:0] s1_eff;
    logic [TAG_W-1:0]      s1_tag;

    logic                  s2_valid;
    logic [SIZE-1:0]       s2_result;
    logic [TAG_W-1:0]      s2_tag;

    logic [CNT_W-1:0]      ops_cnt;

    logic                  s1_adv;
    logic                  s2_adv;
    logic [SHAMT_SIZE-1:0] eff_shamt;
    logic [2*SIZE-1:0]     rot_dbl;
    logic [SIZE-1:0]       rot_res;

    assign s2_adv = !s2_valid || bus.ready_i;
    assign s1_adv = !s1_valid || s2_adv;

    // Right rotate by n equals left rotate by (SIZE - n) mod SIZE, i.e. the two's complement.
    assign eff_shamt = bus.dir_i ? (SHAMT_SIZE'(0) - bus.shamt_i) : bus.shamt_i;

    assign rot_dbl = {s1_data, s1_data} << s1_eff;
    assign rot_res = rot_dbl[2*SIZE-1:SIZE];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_eff    <= '0;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_tag    <= '0;
            ops_cnt   <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result <= rot_res;
                    s2_tag    <= s1_tag;
                end
            end
            if (s1_adv) begin
                s1_valid <= bus.valid_i;
                if (bus.valid_i) begin
                    s1_data <= bus.data_i;
                    s1_eff  <= eff_shamt;
                    s1_tag  <= bus.tag_i;
                end
            end
            if (s2_valid && bus.ready_i) begin
                ops_cnt <= ops_cnt + 1'b1;
            end
        end
    end

    assign bus.ready_o  = s1_adv;
    assign bus.valid_o  = s2_valid;
    assign bus.result_o = s2_result;
    assign bus.tag_o    = s2_tag;
    assign ops_cnt_o    = ops_cnt;
endmodule

// File: tb/tb_bitmanip_rot_pipe.sv
// Randomized and directed checks of bitmanip_rot_pipe against a queue-based rotate model.
module tb_bitmanip_rot_pipe;
    localparam int SIZE  = 16;
    localparam int TAG_W = 4;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [CNT_W-1:0] ops_cnt_o;

    bitmanip_rot_pipe_if #(.SIZE(SIZE), .TAG_W(TAG_W)) bus ();

    bitmanip_rot_pipe #(.SIZE(SIZE), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .bus       (bus.slave),
        .ops_cnt_o (ops_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [SIZE-1:0]  res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             exp_q[$];
    logic [TAG_W-1:0] got_tags[$];
    logic [CNT_W-1:0] cnt_model = '0;
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [SIZE-1:0] ref_rot(input logic [SIZE-1:0] d, input int k, input logic dir);
        logic [31:0] dd;
        logic [31:0] r;
        dd = {16'h0, d};
        if (dir) r = (dd >> k) | (dd << (SIZE - k));
        else     r = (dd << k) | (dd >> (SIZE - k));
        return r[SIZE-1:0];
    endfunction

    // Scoreboard: inputs are stable at the falling edge, so handshakes for the next rising edge are known here.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk("ops_cnt", 32'(ops_cnt_o), 32'(cnt_model));
            if (bus.valid_o && bus.ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(bus.tag_o), 32'hFFFF_FFFF);
                end else begin
                    chk("result", 32'(bus.result_o), 32'(exp_q[0].res));
                    chk("tag", 32'(bus.tag_o), 32'(exp_q[0].tag));
                    void'(exp_q.pop_front());
                end
                got_tags.push_back(bus.tag_o);
                cnt_model <= cnt_model + 1'b1;
            end
            if (bus.valid_i && bus.ready_o) begin
                exp_q.push_back('{res: ref_rot(bus.data_i, int'(bus.shamt_i), bus.dir_i), tag: bus.tag_i});
            end
        end
    end

    task automatic present(input logic [SIZE-1:0] d, input logic [3:0] s, input logic dir, input logic [TAG_W-1:0] t);
        bus.valid_i = 1'b1;
        bus.data_i  = d;
        bus.shamt_i = s;
        bus.dir_i   = dir;
        bus.tag_i   = t;
    endtask

    task automatic wait_accept();
        logic acc;
        int   n;
        n = 0;
        do begin
            @(negedge clk_i);
            acc = bus.ready_o;
            @(posedge clk_i);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("accept_timeout", 32'(n), 32'd0);
        bus.valid_i = 1'b0;
    endtask

    task automatic drive(input logic [SIZE-1:0] d, input logic [3:0] s, input logic dir, input logic [TAG_W-1:0] t);
        present(d, s, dir, t);
        wait_accept();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Single request with ready_i high; checks latency in falling edges and the returned value.
    task automatic run_one(input logic [SIZE-1:0] d, input logic [3:0] s, input logic dir,
                           input logic [TAG_W-1:0] t, input logic [SIZE-1:0] exp_res, input string name);
        int lat;
        drive(d, s, dir, t);
        lat = 1;
        @(negedge clk_i);
        while (!bus.valid_o && lat < 10) begin
            @(negedge clk_i);
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'd2);
        chk(name, 32'(bus.result_o), 32'(exp_res));
        chk({name, "_tag"}, 32'(bus.tag_o), 32'(t));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [SIZE-1:0] held;
        present('0, '0, 1'b0, '0);
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;

        #12;
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_result", 32'(bus.result_o), 32'd0);
        chk("rst_tag", 32'(bus.tag_o), 32'd0);
        chk("rst_cnt", 32'(ops_cnt_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.ready_o), 32'd1);
        @(posedge clk_i);
        #1;

        run_one(16'h8001, 4'd1, 1'b0, 4'd3, 16'h0003, "rol_8001_1");
        chk("cnt_after_first", 32'(ops_cnt_o), 32'd1);
        run_one(16'h8001, 4'd1, 1'b1, 4'd4, 16'hC000, "ror_8001_1");
        run_one(16'h1234, 4'd0, 1'b1, 4'd5, 16'h1234, "ror_1234_0");
        run_one(16'h1234, 4'd4, 1'b0, 4'd6, 16'h2341, "rol_1234_4");
        run_one(16'h1234, 4'd15, 1'b1, 4'd7, 16'h2468, "ror_1234_15");

        // Back-to-back stream: one result per cycle.
        got_tags.delete();
        for (int i = 0; i < 8; i++) begin
            drive(SIZE'($urandom), 4'($urandom), 1'($urandom), TAG_W'(i));
        end
        drain();
        chk("stream_count", 32'(got_tags.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_tags.size(); i++) chk("stream_order", 32'(got_tags[i]), 32'(i));

        // Backpressure: two absorbed, third stalls.
        got_tags.delete();
        bus.ready_i = 1'b0;
        drive(16'hA5A5, 4'd3, 1'b0, 4'd1);
        drive(16'h0F0F, 4'd5, 1'b1, 4'd2);
        present(16'h1357, 4'd9, 1'b0, 4'd3);
        @(negedge clk_i);
        held = bus.result_o;
        chk("bp_result", 32'(held), 32'(ref_rot(16'hA5A5, 3, 1'b0)));
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", 32'(bus.ready_o), 32'd0);
            chk("bp_valid", 32'(bus.valid_o), 32'd1);
            chk("bp_tag", 32'(bus.tag_o), 32'd1);
            chk("bp_stable", 32'(bus.result_o), 32'(held));
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        bus.ready_i = 1'b1;
        wait_accept();
        drain();
        chk("bp_count", 32'(got_tags.size()), 32'd3);
        for (int i = 0; i < 3 && i < got_tags.size(); i++) chk("bp_order", 32'(got_tags[i]), 32'(i + 1));

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            bus.valid_i = 1'($urandom);
            bus.data_i  = SIZE'($urandom);
            bus.shamt_i = 4'($urandom);
            bus.dir_i   = 1'($urandom);
            bus.tag_i   = TAG_W'($urandom);
            bus.ready_i = ($urandom_range(0, 3) != 0);
            @(posedge clk_i);
            #1;
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        drain();

        // Reset with two requests in flight.
        bus.ready_i = 1'b0;
        drive(16'hFFFF, 4'd2, 1'b0, 4'd9);
        drive(16'h00F0, 4'd1, 1'b1, 4'd10);
        chk("pre_rst_valid", 32'(bus.valid_o), 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        exp_q.delete();
        cnt_model = '0;
        chk("mid_rst_valid", 32'(bus.valid_o), 32'd0);
        chk("mid_rst_result", 32'(bus.result_o), 32'd0);
        chk("mid_rst_cnt", 32'(ops_cnt_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        bus.ready_i = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.ready_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("post_rst_no_stale", 32'(bus.valid_o), 32'd0);
        end
        @(posedge clk_i);
        #1;

        // Counter wrap with CNT_W=4.
        for (int i = 0; i < 15; i++) drive(SIZE'($urandom), 4'($urandom), 1'($urandom), TAG_W'(i));
        drain();
        chk("cnt_15", 32'(ops_cnt_o), 32'd15);
        drive(16'h0001, 4'd1, 1'b0, 4'd0);
        drain();
        chk("cnt_wrap_0", 32'(ops_cnt_o), 32'd0);
        drive(16'h0001, 4'd1, 1'b1, 4'd1);
        drain();
        chk("cnt_1", 32'(ops_cnt_o), 32'd1);

        repeat (2) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got %0t exp below 200000", $time);
        $fatal(1);
    end
endmodule

// File: doc/bitmanip_rot_pipe.md
Name: bitmanip_rot_pipe

Overview:
Pipelined rotate unit with valid/ready handshakes. It sits directly upstream of the bitmanip result consumer and holds the rotate datapath.
- Stage 1 accepts operand requests, normalizes ROR into an equivalent ROL amount and registers them.
- Stage 2 performs the rotate and registers the result, with full backpressure support.
- It also maintains a completed-operation counter for bring-up and performance checks.

Parameters:
SIZE, 16, data width in bits; must be a power of two, at least 2.
SHAMT_SIZE, $clog2(SIZE), shift-amount width.
TAG_W, 4, width of the opaque request tag carried alongside the data.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous reset, active-high.
valid_i  input  1  request valid.
ready_o  output  1  request accepted when valid_i && ready_o at a clock edge.
data_i  input  SIZE  operand.
shamt_i  input  SHAMT_SIZE  rotate amount.
dir_i  input  1  0 = rotate left, 1 = rotate right.
tag_i  input  TAG_W  request tag, returned unchanged with the result.
valid_o  output  1  result valid.
ready_i  input  1  downstream ready; the result transfers on valid_o && ready_i.
result_o  output  SIZE  rotated operand.
tag_o  output  TAG_W  tag of the request that produced result_o.
ops_cnt_o  output  CNT_W  count of completed output handshakes.

Behaviour:
- Reset: one clock; rst_i is asynchronous and active-high. Asserting rst_i immediately clears all state:
  - s1_valid = 0, s2_valid = 0, so valid_o = 0;
  - result_o = 0, tag_o = 0, ops_cnt_o = 0;
  - all stage data registers = 0.
  In-flight requests are dropped with no partial output. After rst_i deasserts, ready_o is 1.
- Normalization (S1 capture):
  - eff_shamt = dir_i ? (SIZE - shamt_i) mod SIZE : shamt_i, computed in SHAMT_SIZE bits with natural wrap.
  - Consequently ROR by 0 gives eff_shamt = 0 (no rotation).
  - S1 registers data, eff_shamt and tag.
- Rotate (S2 capture): s2_result = rotate-left of s1_data by s1_eff, computed as the upper SIZE bits of {s1_data, s1_data} << s1_eff. s2_tag = s1_tag.
- Outputs: result_o, tag_o and valid_o are driven directly from S2 registers. There is no combinational path from data_i to result_o.
- Advance rules:
  - s2_adv = !s2_valid || ready_i.
  - s1_adv = !s1_valid || s2_adv.
  - ready_o = s1_adv. This is a combinational path from ready_i to ready_o, by design.
  - On s2_adv: s2_valid <= s1_valid, and S2 data loads from S1 only when s1_valid = 1.
  - On s1_adv: s1_valid <= valid_i, and S1 data loads only when valid_i = 1.
- Registers that are not loaded hold their value, so result_o and tag_o are stable while valid_o && !ready_i.
- Latency and throughput:
  - Exactly 2 cycles from the accept edge to valid_o, when ready_i is held high.
  - Sustained throughput is 1 operation per cycle.
- Backpressure: with ready_i = 0, the pipe absorbs up to 2 requests. ready_o then drops to 0 in the cycle both stages hold valid data. There is no loss and no duplication, and results appear strictly in acceptance order.
- Counter: ops_cnt_o increments by 1 on each valid_o && ready_i edge and wraps from 2^CNT_W-1 to 0. It is unaffected by input handshakes.
- Simultaneous events: an output handshake and a new input acceptance in the same cycle both complete. The pipe shifts and the occupancy is unchanged.
- Protocol: once valid_o rises it stays high, with stable result_o and tag_o, until ready_i samples 1. The block does not require valid_i to be held, but X on data_i is tolerated only when valid_i = 0.

Test Plan:
1. SIZE=16, ready_i=1: ROL data=0x8001 shamt=1 tag=3 -> 2 cycles later valid_o=1, result_o=0x0003, tag_o=3, ops_cnt_o=1 after the handshake.
2. ROR data=0x8001 shamt=1 -> result 0xC000. ROR data=0x1234 shamt=0 -> 0x1234. ROL data=0x1234 shamt=4 -> 0x2341. ROR data=0x1234 shamt=15 -> 0x2468.
3. Back-to-back stream of 8 random ROL/ROR requests with ready_i=1 -> one result per cycle, each matching the reference model, with tags in issue order.
4. Backpressure: ready_i=0, drive 3 requests (tags 1, 2, 3) -> tags 1 and 2 accepted, ready_o=0 on the third. Hold ready_i=0 for 5 cycles: valid_o=1 with tag_o=1 stable throughout. Release ready_i -> tags 1, 2, 3 delivered in order with correct results.
5. Reset mid-operation: 2 requests in flight, assert rst_i between clock edges -> valid_o, result_o and ops_cnt_o are 0 immediately. After release, ready_o=1 and no stale result ever appears.
6. CNT_W=4: complete 17 operations -> ops_cnt_o reads 15 after 15 handshakes, wraps to 0 after 16, and reads 1 after 17.
